// File: rtl/debug_capture_if.sv
// rtl/debug_capture_if.sv - readout stream bundle for the debug capture buffer
interface debug_capture_if #(
  parameter int DATA_W = 256
);
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_last;
  logic              rd_ready;

  modport master (output rd_data, output rd_valid, output rd_last, input rd_ready);
  modport slave  (input rd_data, input rd_valid, input rd_last, output rd_ready);
endinterface

// File: rtl/debug_capture.sv
// rtl/debug_capture.sv - triggered circular-buffer capture of one debug channel
// with pre-trigger history and a stall-tolerant chronological readout.
module debug_capture #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 256,
  parameter int DEPTH  = 1024,
  parameter int SEL_W  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk_100mhz,
  input  logic                     sys_rst_n,
  input  logic [NUM_CH*DATA_W-1:0] dbg_bus,
  input  logic [SEL_W-1:0]         ch_sel,
  input  logic [DATA_W-1:0]        trig_mask,
  input  logic [DATA_W-1:0]        trig_value,
  input  logic [ADDR_W-1:0]        pre_len,
  input  logic                     arm,
  input  logic                     abort,
  debug_capture_if.master          rd,
  output logic [2:0]               state_o,
  output logic [ADDR_W-1:0]        trig_addr
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_READ = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [2:0]        state;
  logic [CH_W-1:0]   ch_q;
  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] value_q;
  logic [ADDR_W-1:0] pre_q;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W:0]   issued;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [DATA_W-1:0] sample;
  logic [DATA_W-1:0] ram_q;
  logic              a_valid;
  logic              a_last;

  logic              capturing;
  logic              hit;
  logic              fill_done;
  logic              post_done;
  logic [ADDR_W-1:0] post_len;
  logic              out_take;
  logic              a_take;
  logic              issue;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_data[k] = dbg_bus[k*DATA_W +: DATA_W];
  end

  assign sample  = ch_data[ch_q];
  assign state_o = state;

  always_comb begin
    capturing = (state == S_FILL) || (state == S_WAIT) || (state == S_POST);
    hit       = ((sample ^ value_q) & mask_q) == '0;
    post_len  = LAST_ADDR - pre_q;
    fill_done = (cnt == pre_q - 1'b1);
    post_done = (cnt == post_len - 1'b1);
    // Two-stage read pipeline: RAM register feeds the output register.
    out_take  = !rd.rd_valid || rd.rd_ready;
    a_take    = !a_valid || out_take;
    issue     = (state == S_READ) && !issued[ADDR_W] && a_take && !abort;
  end

  always_ff @(posedge clk_100mhz) begin
    if (capturing) mem[ptr] <= sample;
    if (issue)     ram_q    <= mem[ptr];
  end

  always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= S_IDLE;
      ch_q        <= '0;
      mask_q      <= '0;
      value_q     <= '0;
      pre_q       <= '0;
      ptr         <= '0;
      cnt         <= '0;
      issued      <= '0;
      trig_addr   <= '0;
      a_valid     <= 1'b0;
      a_last      <= 1'b0;
      rd.rd_data  <= '0;
      rd.rd_valid <= 1'b0;
      rd.rd_last  <= 1'b0;
    end else if (abort) begin
      state       <= S_IDLE;
      a_valid     <= 1'b0;
      a_last      <= 1'b0;
      rd.rd_valid <= 1'b0;
      rd.rd_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (arm) begin
          ch_q    <= (32'(ch_sel) < NUM_CH) ? CH_W'(ch_sel) : '0;
          mask_q  <= trig_mask;
          value_q <= trig_value;
          pre_q   <= pre_len;
          ptr     <= '0;
          cnt     <= '0;
          issued  <= '0;
          state   <= (pre_len != '0) ? S_FILL : S_WAIT;
        end
        S_FILL: begin
          ptr <= ptr + 1'b1;
          cnt <= fill_done ? '0 : cnt + 1'b1;
          if (fill_done) state <= S_WAIT;
        end
        S_WAIT: begin
          ptr <= ptr + 1'b1;
          if (hit) begin
            trig_addr <= ptr;
            cnt       <= '0;
            state     <= (post_len == '0) ? S_READ : S_POST;
          end
        end
        S_POST: begin
          ptr <= ptr + 1'b1;
          cnt <= cnt + 1'b1;
          if (post_done) state <= S_READ;
        end
        // The final capture write leaves ptr at trig_addr - pre_len, the oldest sample.
        S_READ: begin
          if (issue) begin
            ptr    <= ptr + 1'b1;
            issued <= issued + 1'b1;
          end
          if (rd.rd_valid && rd.rd_ready && rd.rd_last) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (issue) begin
        a_valid <= 1'b1;
        a_last  <= &issued[ADDR_W-1:0];
      end else if (a_take) begin
        a_valid <= 1'b0;
      end

      if (out_take) begin
        rd.rd_valid <= a_valid;
        rd.rd_last  <= a_valid && a_last;
        if (a_valid) rd.rd_data <= ram_q;
      end
    end
  end
endmodule

// File: tb/tb_debug_capture.sv
// tb/tb_debug_capture.sv - randomized and directed checks of debug_capture
// against a sample-list reference model.
module tb_debug_capture;
  localparam int DEPTH = 16;
  localparam int NSAMP = 340;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dbg_bus;
  logic [7:0]  ch_sel;
  logic [7:0]  trig_mask;
  logic [7:0]  trig_value;
  logic [3:0]  pre_len;
  logic        arm;
  logic        abort;
  logic [2:0]  state_o;
  logic [3:0]  trig_addr;

  debug_capture_if #(.DATA_W(8)) rd_if ();

  debug_capture #(
    .NUM_CH(4), .DATA_W(8), .DEPTH(DEPTH), .SEL_W(8)
  ) dut (
    .clk_100mhz (clk),
    .sys_rst_n  (rst_n),
    .dbg_bus    (dbg_bus),
    .ch_sel     (ch_sel),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .pre_len    (pre_len),
    .arm        (arm),
    .abort      (abort),
    .rd         (rd_if),
    .state_o    (state_o),
    .trig_addr  (trig_addr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] bus_q [$];
  logic [7:0]  exp_q [$];
  int          exp_trig;
  int          total;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: samples s[i] are the selected channel on the i-th write after arm.
  // Trigger index t is the first i >= pre matching; readout is s[t-pre .. t-pre+DEPTH-1].
  task automatic build(input int sel, input logic [7:0] m, input logic [7:0] v,
                       input int p, input bit counter);
    int          eff;
    int          t;
    logic [31:0] w;
    logic [7:0]  s [$];
    eff = (sel >= 4) ? 0 : sel;
    bus_q.delete();
    exp_q.delete();
    for (int i = 0; i < NSAMP; i++) begin
      w = $urandom;
      if (counter) w[eff*8 +: 8] = 8'(i);
      bus_q.push_back(w);
      s.push_back(w[eff*8 +: 8]);
    end
    t = -1;
    for (int i = p; i < 300 && t < 0; i++)
      if ((s[i] & m) == (v & m)) t = i;
    if (t < 0) begin
      t = p + 20;
      w = bus_q[t];
      w[eff*8 +: 8] = v;
      bus_q[t] = w;
      s[t] = v;
    end
    exp_trig = t % DEPTH;
    total    = t + DEPTH - p;
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(s[t - p + k]);
  endtask

  task automatic arm_and_drive(input int sel, input logic [7:0] m, input logic [7:0] v,
                               input int p, input int n, input bit arm_glitch);
    ch_sel     = 8'(sel);
    trig_mask  = m;
    trig_value = v;
    pre_len    = 4'(p);
    arm        = 1'b1;
    dbg_bus    = $urandom;
    @(posedge clk); #1;
    arm = 1'b0;
    check("arm_state", 32'(state_o), (p > 0) ? 32'd1 : 32'd2);
    ch_sel     = 8'($urandom);
    trig_mask  = 8'($urandom);
    trig_value = 8'($urandom);
    pre_len    = 4'($urandom);
    for (int i = 0; i < n; i++) begin
      dbg_bus = bus_q[i];
      arm     = arm_glitch && (i == n - 2);
      @(posedge clk); #1;
      arm = 1'b0;
    end
  endtask

  task automatic capture(input int sel, input logic [7:0] m, input logic [7:0] v,
                         input int p, input bit counter, input bit arm_glitch);
    build(sel, m, v, p, counter);
    arm_and_drive(sel, m, v, p, total, arm_glitch);
    check("in_read", 32'(state_o), 32'd4);
    check("trig_addr", 32'(trig_addr), 32'(exp_trig));
  endtask

  task automatic readout(input bit random_ready, input int abort_at);
    int         k = 0;
    int         cyc = 0;
    int         first = -1;
    bit         rdy;
    bit         pstall = 1'b0;
    bit         aborted = 1'b0;
    logic       v;
    logic       l;
    logic       pl = 1'b0;
    logic [7:0] d;
    logic [7:0] pd = '0;
    while (k < DEPTH && cyc < 400 && !aborted) begin
      rdy = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (abort_at == k && rd_if.rd_valid) begin
        abort = 1'b1;
        rdy   = 1'b1;
      end
      rd_if.rd_ready = rdy;
      if (pstall) begin
        check("stall_valid", 32'(rd_if.rd_valid), 32'd1);
        check("stall_data", 32'(rd_if.rd_data), 32'(pd));
        check("stall_last", 32'(rd_if.rd_last), 32'(pl));
      end
      if (rd_if.rd_valid && first < 0) first = cyc;
      v = rd_if.rd_valid;
      d = rd_if.rd_data;
      l = rd_if.rd_last;
      @(posedge clk); #1;
      cyc++;
      if (abort) begin
        abort   = 1'b0;
        aborted = 1'b1;
        check("abort_state", 32'(state_o), 32'd0);
        check("abort_valid", 32'(rd_if.rd_valid), 32'd0);
        check("abort_last", 32'(rd_if.rd_last), 32'd0);
      end else if (v && rdy) begin
        check("rd_data", 32'(d), 32'(exp_q[k]));
        check("rd_last", 32'(l), (k == DEPTH - 1) ? 32'd1 : 32'd0);
        k++;
      end
      pstall = v && !rdy && !aborted;
      pd = d;
      pl = l;
    end
    rd_if.rd_ready = 1'b0;
    if (!aborted) begin
      check("read_count", 32'(k), 32'(DEPTH));
      check("rd_latency", 32'(first >= 0 && first <= 2), 32'd1);
      if (!random_ready) check("throughput", 32'(cyc - first), 32'(DEPTH));
      check("done_state", 32'(state_o), 32'd0);
      check("done_valid", 32'(rd_if.rd_valid), 32'd0);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    dbg_bus        = '0;
    ch_sel         = '0;
    trig_mask      = '0;
    trig_value     = '0;
    pre_len        = '0;
    arm            = 1'b0;
    abort          = 1'b0;
    rd_if.rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_valid", 32'(rd_if.rd_valid), 32'd0);
    check("rst_last", 32'(rd_if.rd_last), 32'd0);
    check("rst_data", 32'(rd_if.rd_data), 32'd0);
    check("rst_trig", 32'(trig_addr), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic capture: counter on channel 2, trigger on 0x0A with 4 pre samples.
    capture(2, 8'hFF, 8'h0A, 4, 1'b1, 1'b0);
    check("basic_trig_10", 32'(trig_addr), 32'd10);
    check("basic_first", 32'(exp_q[0]), 32'h06);
    readout(1'b0, -1);

    // Mask zero, no pre-trigger history: first sample triggers.
    capture(1, 8'h00, 8'h00, 0, 1'b0, 1'b0);
    readout(1'b1, -1);

    // Wrap: 15 pre samples, trigger at sample 40.
    capture(0, 8'hFF, 8'd40, 15, 1'b1, 1'b0);
    check("wrap_trig_8", 32'(trig_addr), 32'd8);
    readout(1'b1, -1);

    for (int r = 0; r < 4; r++) begin
      capture(int'($urandom_range(0, 7)),
              8'(1 << $urandom_range(0, 7)) | 8'(1 << $urandom_range(0, 7)),
              8'($urandom), int'($urandom_range(0, 15)), 1'b0, 1'b0);
      readout(1'b1, -1);
    end

    // Abort together with arm in IDLE stays idle.
    arm   = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    arm   = 1'b0;
    abort = 1'b0;
    check("arm_abort_idle", 32'(state_o), 32'd0);

    // Abort while waiting for a trigger that never comes.
    ch_sel     = 8'd1;
    trig_mask  = 8'hFF;
    trig_value = 8'h5A;
    pre_len    = 4'd0;
    dbg_bus    = '0;
    arm        = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("wait_hold", 32'(state_o), 32'd2);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_wait_state", 32'(state_o), 32'd0);
    check("abort_wait_valid", 32'(rd_if.rd_valid), 32'd0);
    capture(3, 8'h0F, 8'h03, 7, 1'b1, 1'b0);
    readout(1'b0, -1);

    // Abort mid-burst, then re-arm.
    capture(2, 8'hFF, 8'h09, 5, 1'b1, 1'b0);
    readout(1'b0, 5);
    capture(int'($urandom_range(0, 3)), 8'h03, 8'($urandom), 9, 1'b0, 1'b0);
    readout(1'b1, -1);

    // Out-of-range select falls back to channel 0; arm during capture is ignored.
    capture(7, 8'hFF, 8'h20, 3, 1'b1, 1'b1);
    readout(1'b1, -1);

    // Reset pulse during POST.
    build(3, 8'h00, 8'h00, 2, 1'b1);
    arm_and_drive(3, 8'h00, 8'h00, 2, 6, 1'b0);
    check("in_post", 32'(state_o), 32'd3);
    check("post_trig", 32'(trig_addr), 32'd2);
    rst_n = 1'b0;
    #2;
    check("mid_rst_state", 32'(state_o), 32'd0);
    check("mid_rst_valid", 32'(rd_if.rd_valid), 32'd0);
    check("mid_rst_last", 32'(rd_if.rd_last), 32'd0);
    check("mid_rst_data", 32'(rd_if.rd_data), 32'd0);
    check("mid_rst_trig", 32'(trig_addr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(state_o), 32'd0);
    check("post_rst_valid", 32'(rd_if.rd_valid), 32'd0);
    capture(1, 8'hC0, 8'($urandom), 12, 1'b0, 1'b0);
    readout(1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/debug_capture.md
DEBUG_CAPTURE -- requirements
Module: debug_capture

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of debug channels on dbg_bus.
REQ-002 SHALL have parameter DATA_W, default 256, width of one channel.
REQ-003 SHALL have parameter DEPTH, default 1024, capture samples (power of 2, >= 4).
REQ-004 SHALL have parameter SEL_W, default 8, channel-select width; ADDR_W = log2(DEPTH) is derived.
REQ-005 SHALL have port clk_100mhz  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port dbg_bus  input  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port ch_sel  input  SEL_W  channel index, sampled on arm.
REQ-009 SHALL have port trig_mask / trig_value  input  DATA_W each  trigger compare, sampled on arm.
REQ-010 SHALL have port pre_len  input  ADDR_W  pre-trigger sample count, sampled on arm.
REQ-011 SHALL have port arm / abort  input  1 each  single-cycle pulses.
REQ-012 SHALL have port rd_ready  input  1  readout sink ready.
REQ-013 SHALL have port rd_data  output  DATA_W  readout sample.
REQ-014 SHALL have port rd_valid / rd_last  output  1 each  readout qualifier / final sample.
REQ-015 SHALL have port state_o  output  3  IDLE=0, FILL=1, WAIT_TRIG=2, POST=3, READ=4.
REQ-016 SHALL have port trig_addr  output  ADDR_W  buffer address of trigger sample.

Function
REQ-017 SHALL, on arm in IDLE (cycle N), latch ch_sel, trig_mask, trig_value, pre_len; ch_sel >= NUM_CH selects channel 0.
REQ-018 SHALL clamp latched pre_len to DEPTH-1.
REQ-019 SHALL write the selected channel into the circular buffer once per cycle from cycle N+1 onward in FILL, WAIT_TRIG and POST; write pointer starts at 0 on arm and wraps DEPTH-1 -> 0.
REQ-020 SHALL go IDLE -> FILL on arm when pre_len > 0, IDLE -> WAIT_TRIG when pre_len = 0.
REQ-021 SHALL leave FILL for WAIT_TRIG after exactly pre_len samples are written; no trigger is evaluated in FILL.
REQ-022 SHALL, in WAIT_TRIG, detect trigger when (sample & trig_mask) == (trig_value & trig_mask), evaluated on the sample written that cycle; trig_mask = 0 triggers on the first WAIT_TRIG sample.
REQ-023 SHALL, on trigger, store that sample's address in trig_addr and go to POST.
REQ-024 SHALL write DEPTH-1-pre_len further samples in POST, then go to READ; a trigger with DEPTH-1-pre_len = 0 goes directly to READ.
REQ-025 SHALL, in READ, present DEPTH samples in chronological order starting at address (trig_addr - pre_len) mod DEPTH, so the trigger sample is sample index pre_len.
REQ-026 SHALL assert rd_valid within 2 cycles of entering READ; a sample transfers when rd_valid and rd_ready are both high; rd_data and rd_last are held stable while rd_valid and not rd_ready.
REQ-027 SHALL sustain one transfer per cycle with rd_ready held high (registered RAM read, prefetch allowed).
REQ-028 SHALL assert rd_last only with the DEPTH-th sample; after its transfer, go to IDLE and deassert rd_valid the next cycle.
REQ-029 SHALL ignore arm outside IDLE.
REQ-030 SHALL, on abort in any state, enter IDLE the next cycle with rd_valid = 0 and rd_last = 0; abort has priority over arm, trigger and transfer in the same cycle.
REQ-031 SHALL, on abort and arm together in IDLE, remain IDLE.
REQ-032 SHALL keep trig_addr unchanged from trigger until the next trigger or reset.

Reset
REQ-033 SHALL, while sys_rst_n = 0, force state_o = 0, rd_valid = 0, rd_last = 0, rd_data = 0, trig_addr = 0, pointers/counters = 0; buffer contents need not be reset.
REQ-034 SHALL, on reset asserted mid-capture or mid-readout, discard the capture; after release, wait in IDLE for a new arm.

Verification (NUM_CH=4, DATA_W=8, DEPTH=16)
REQ-035 SHALL cover basic capture: ch_sel=2, channel 2 = free-running counter starting at 0 on the cycle after arm, pre_len=4, mask=FF, value=0A -> trig_addr=10, readout 06..15 (16 values), rd_last on 15.
REQ-036 SHALL cover pre_len=0, mask=00 -> trigger on the first sample, 16 samples read, first sample = trigger sample.
REQ-037 SHALL cover wrap: pre_len=15, trigger at sample 40 -> readout 25..40, rd_last on 40, trig_addr = 40 mod 16 = 8.
REQ-038 SHALL cover backpressure: rd_ready toggled randomly -> no sample lost or duplicated, rd_data stable while stalled.
REQ-039 SHALL cover abort in WAIT_TRIG and in READ mid-burst -> state_o=0 next cycle, rd_valid=0; re-arm captures correctly.
REQ-040 SHALL cover ch_sel=7 -> channel 0 captured; sys_rst_n pulse during POST -> all outputs 0, IDLE after release.
